// File: rtl/op_pkg.sv
// Shared definitions for the operation-select path: op codes, main-FSM state
// encodings used by the display and top FSM, and the op code validity check.
package op_pkg;

   localparam logic [3:0] OP_T = 4'b0001;
   localparam logic [3:0] OP_A = 4'b0010;
   localparam logic [3:0] OP_B = 4'b0100;
   localparam logic [3:0] OP_C = 4'b1000;
   localparam logic [3:0] OP_D = 4'b1111;

   typedef enum logic [3:0] {
      MS_RESET   = 4'd0,
      MS_MENU    = 4'd1,
      MS_SELECT  = 4'd2,
      MS_INPUT_A = 4'd3,
      MS_INPUT_B = 4'd4,
      MS_COMPUTE = 4'd5,
      MS_RESULT  = 4'd6,
      MS_ERROR   = 4'd7,
      MS_TIMEOUT = 4'd8,
      MS_DONE    = 4'd9
   } main_state_t;

   typedef enum logic [1:0] {
      SEL_IDLE  = 2'd0,
      SEL_ARMED = 2'd1,
      SEL_LOCK  = 2'd2,
      SEL_DONE  = 2'd3
   } sel_state_t;

   function automatic logic op_is_valid(input logic [3:0] code);
      case (code)
         OP_T, OP_A, OP_B, OP_C, OP_D: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/op_select_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a one-cycle
// pulse on each debounced rising edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             raw_p0;
   logic             raw_p1;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_p0     <= 1'b0;
         raw_p1     <= 1'b0;
         level      <= 1'b0;
         cnt        <= '0;
         rise_pulse <= 1'b0;
      end else begin
         raw_p0     <= raw;
         raw_p1     <= raw_p0;
         rise_pulse <= 1'b0;
         // Any cycle agreeing with the current level restarts the stability window
         if (raw_p1 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level      <= ~level;
            cnt        <= '0;
            rise_pulse <= ~level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/op_select.sv
// Converts switches plus a debounced confirm press into an accepted op code,
// with a whole-second lockout countdown after an invalid selection.
module op_select
   import op_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int SEC_CYCLES      = 100_000_000,
   parameter int TIMEOUT_S       = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       select_en,
   input  logic [3:0] sw,
   input  logic       btn_confirm,
   output logic [3:0] op_type,
   output logic       op_valid,
   output logic       op_error,
   output logic       busy,
   output logic [3:0] sec_left
);

   localparam int TICK_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SEC_CYCLES - 1);
   localparam logic [3:0]        SEC_INIT = 4'(TIMEOUT_S);

   logic [3:0]        sw_p0;
   logic [3:0]        sw_p1;
   logic              btn_level;
   logic              btn_rise;
   logic              press;

   sel_state_t        state,    state_nx;
   logic [TICK_W-1:0] tick,     tick_nx;
   logic [3:0]        sec_nx;
   logic              busy_nx;
   logic [3:0]        op_type_nx;
   logic              op_valid_nx;
   logic              op_error_nx;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (btn_confirm),
      .level     (btn_level),
      .rise_pulse(btn_rise)
   );

   assign press = btn_rise & btn_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_p0    <= '0;
         sw_p1    <= '0;
         state    <= SEL_IDLE;
         tick     <= '0;
         sec_left <= '0;
         busy     <= 1'b0;
         op_type  <= '0;
         op_valid <= 1'b0;
         op_error <= 1'b0;
      end else begin
         sw_p0    <= sw;
         sw_p1    <= sw_p0;
         state    <= state_nx;
         tick     <= tick_nx;
         sec_left <= sec_nx;
         busy     <= busy_nx;
         op_type  <= op_type_nx;
         op_valid <= op_valid_nx;
         op_error <= op_error_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      tick_nx     = tick;
      sec_nx      = sec_left;
      busy_nx     = busy;
      op_type_nx  = op_type;
      op_valid_nx = 1'b0;
      op_error_nx = 1'b0;
      // Leaving the menu overrides any press or second boundary in the same cycle
      if (state != SEL_IDLE && !select_en) begin
         state_nx = SEL_IDLE;
         tick_nx  = '0;
         sec_nx   = '0;
         busy_nx  = 1'b0;
      end else begin
         case (state)
            SEL_IDLE: begin
               if (select_en) state_nx = SEL_ARMED;
            end
            SEL_ARMED: begin
               if (press) begin
                  if (op_is_valid(sw_p1)) begin
                     op_type_nx  = sw_p1;
                     op_valid_nx = 1'b1;
                     state_nx    = SEL_DONE;
                  end else begin
                     op_error_nx = 1'b1;
                     sec_nx      = SEC_INIT;
                     tick_nx     = '0;
                     busy_nx     = 1'b1;
                     state_nx    = SEL_LOCK;
                  end
               end
            end
            SEL_LOCK: begin
               if (tick == TICK_MAX) begin
                  tick_nx = '0;
                  if (sec_left > 4'd1) begin
                     sec_nx = sec_left - 4'd1;
                  end else begin
                     sec_nx   = '0;
                     busy_nx  = 1'b0;
                     state_nx = SEL_ARMED;
                  end
               end else begin
                  tick_nx = tick + 1'b1;
               end
            end
            SEL_DONE: begin
               state_nx = SEL_DONE;
            end
            default: begin
               state_nx = SEL_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_op_select.sv
// Directed bench for op_select with short debounce/second/timeout parameters.
module tb_op_select;

   localparam int DEB = 4;
   localparam int SEC = 10;
   localparam int TMO = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       select_en;
   logic [3:0] sw;
   logic       btn_confirm;
   logic [3:0] op_type;
   logic       op_valid;
   logic       op_error;
   logic       busy;
   logic [3:0] sec_left;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int nv    = 0;
   int ne    = 0;
   int last_v = 0;
   int t0;
   int nv0;
   int ne0;

   op_select #(
      .DEBOUNCE_CYCLES(DEB),
      .SEC_CYCLES     (SEC),
      .TIMEOUT_S      (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .select_en  (select_en),
      .sw         (sw),
      .btn_confirm(btn_confirm),
      .op_type    (op_type),
      .op_valid   (op_valid),
      .op_error   (op_error),
      .busy       (busy),
      .sec_left   (sec_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n cycles, sampling on the falling edge and tallying output pulses
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (op_valid) begin
            nv++;
            last_v = cyc;
         end
         if (op_error) ne++;
      end
   endtask

   task automatic rearm();
      select_en = 1'b0;
      run(2);
      select_en = 1'b1;
      run(2);
   endtask

   initial begin
      rst_n       = 1'b0;
      select_en   = 1'b0;
      sw          = 4'b0000;
      btn_confirm = 1'b0;
      run(3);
      check("rst_op_type",  op_type,  4'h0);
      check("rst_op_valid", op_valid, 1'b0);
      check("rst_op_error", op_error, 1'b0);
      check("rst_busy",     busy,     1'b0);
      check("rst_sec_left", sec_left, 4'h0);
      rst_n = 1'b1;
      run(2);

      // Valid accept with latency check
      select_en = 1'b1;
      sw        = 4'b0010;
      run(4);
      nv0 = nv; ne0 = ne;
      btn_confirm = 1'b1;
      t0 = cyc;
      run(10);
      check("acc_pulses",  nv - nv0,    1);
      check("acc_latency", last_v - t0, 7);
      check("acc_op_type", op_type,     4'b0010);
      check("acc_no_err",  ne - ne0,    0);
      btn_confirm = 1'b0;
      run(8);

      // Bounce rejection
      rearm();
      sw = 4'b0100;
      run(3);
      nv0 = nv;
      btn_confirm = 1'b1; run(2);
      btn_confirm = 1'b0; run(2);
      btn_confirm = 1'b1; run(2);
      btn_confirm = 1'b0; run(2);
      check("bounce_no_press", nv - nv0, 0);
      btn_confirm = 1'b1;
      run(9);
      check("bounce_one_press", nv - nv0, 1);
      check("bounce_op_type",   op_type,  4'b0100);
      btn_confirm = 1'b0;
      run(8);

      // Invalid code and lockout countdown
      rearm();
      sw = 4'b0011;
      run(3);
      nv0 = nv;
      btn_confirm = 1'b1;
      run(7);
      check("inv_op_error", op_error, 1'b1);
      check("inv_busy",     busy,     1'b1);
      check("inv_sec3",     sec_left, 4'd3);
      check("inv_op_keep",  op_type,  4'b0100);
      ne0 = ne;
      btn_confirm = 1'b0;
      run(10);
      check("lock_sec2", sec_left, 4'd2);
      btn_confirm = 1'b1;
      run(10);
      check("lock_sec1", sec_left, 4'd1);
      btn_confirm = 1'b0;
      run(10);
      check("lock_sec0",     sec_left, 4'd0);
      check("lock_busy0",    busy,     1'b0);
      check("lock_no_valid", nv - nv0, 0);
      check("lock_no_error", ne - ne0, 0);
      sw = 4'b1111;
      btn_confirm = 1'b1;
      run(7);
      check("post_lock_valid", op_valid, 1'b1);
      check("post_lock_op",    op_type,  4'b1111);
      btn_confirm = 1'b0;
      run(8);

      // Button held through the whole lockout
      rearm();
      sw = 4'b0000;
      run(3);
      btn_confirm = 1'b1;
      run(7);
      check("held_op_error", op_error, 1'b1);
      run(30);
      check("held_busy0", busy,     1'b0);
      check("held_sec0",  sec_left, 4'd0);
      nv0 = nv;
      run(10);
      check("held_no_valid", nv - nv0, 0);
      btn_confirm = 1'b0;
      sw = 4'b0010;
      run(8);
      btn_confirm = 1'b1;
      run(7);
      check("repress_valid", op_valid, 1'b1);
      check("repress_op",    op_type,  4'b0010);
      btn_confirm = 1'b0;
      run(8);

      // Abort lockout by dropping select_en
      rearm();
      sw = 4'b0101;
      run(3);
      btn_confirm = 1'b1;
      run(7);
      check("abort_err", op_error, 1'b1);
      btn_confirm = 1'b0;
      run(10);
      check("abort_sec2", sec_left, 4'd2);
      select_en = 1'b0;
      run(1);
      check("abort_busy0", busy,     1'b0);
      check("abort_sec0",  sec_left, 4'd0);
      check("abort_op",    op_type,  4'b0010);

      // Asynchronous reset in the middle of a lockout
      select_en = 1'b1;
      run(2);
      sw = 4'b0110;
      run(3);
      btn_confirm = 1'b1;
      run(7);
      check("mid_err", op_error, 1'b1);
      btn_confirm = 1'b0;
      run(5);
      check("mid_busy1", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_op_type",  op_type,  4'h0);
      check("arst_sec_left", sec_left, 4'h0);
      check("arst_busy",     busy,     1'b0);
      check("arst_op_valid", op_valid, 1'b0);
      check("arst_op_error", op_error, 1'b0);
      run(2);
      rst_n = 1'b1;
      run(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
